// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline stages: fetch FSM encoding,
// default bubble instruction and PC step.
package arm_pkg;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_KILL  = 2'd1,
    IF_HOLD  = 2'd2
  } if_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Branch targets are word addresses; the low two bits carry no meaning.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register between two stages: flush inserts a bubble,
// freeze holds every field, otherwise it loads or drops to a bubble.
module if_id_reg #(
  parameter logic [31:0] NOP_WORD = arm_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        freeze_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        valid_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_WORD;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_WORD;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (!freeze_i) begin
      if (load_i) begin
        instr_q <= instr_i;
        pc_q    <= pc_i;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, drives a variable-latency instruction
// memory port and feeds the IF/ID register without dropping or repeating words.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = arm_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        valid
);

  import arm_pkg::*;

  if_state_t   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  logic        ack;
  logic        load;
  logic [31:0] load_instr;
  logic [31:0] load_pc;
  logic [31:0] br_target;
  logic [31:0] pc_plus;

  assign imem_req  = rst && (state_q != IF_HOLD);
  assign imem_addr = fetch_pc_q;
  // An ack with no live request (HOLD or reset) belongs to an abandoned fetch.
  assign ack       = imem_ack && imem_req;
  assign br_target = word_align(branch_addr);
  assign pc_plus   = fetch_pc_q + PC_STEP;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;
    load          = 1'b0;
    load_instr    = imem_rdata;
    load_pc       = pc_plus;

    case (state_q)
      IF_FETCH: begin
        if (branch_taken) begin
          if (ack) begin
            fetch_pc_d = br_target;
          end else begin
            // Keep the outstanding address stable until its ack drains.
            redirect_pc_d = br_target;
            state_d       = IF_KILL;
          end
        end else if (ack) begin
          fetch_pc_d = pc_plus;
          if (freeze) begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = pc_plus;
            state_d     = IF_HOLD;
          end else begin
            load = 1'b1;
          end
        end
      end
      IF_KILL: begin
        if (ack) begin
          fetch_pc_d = branch_taken ? br_target : redirect_pc_q;
          state_d    = IF_FETCH;
        end else if (branch_taken) begin
          redirect_pc_d = br_target;
        end
      end
      IF_HOLD: begin
        if (branch_taken) begin
          fetch_pc_d = br_target;
          state_d    = IF_FETCH;
        end else if (!freeze) begin
          load       = 1'b1;
          load_instr = buf_instr_q;
          load_pc    = buf_pc_q;
          state_d    = IF_FETCH;
        end
      end
      default: state_d = IF_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IF_FETCH;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= '0;
      buf_instr_q   <= NOP_INSTR;
      buf_pc_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      buf_instr_q   <= buf_instr_d;
      buf_pc_q      <= buf_pc_d;
    end
  end

  if_id_reg #(
    .NOP_WORD (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst),
    .flush_i  (branch_taken),
    .freeze_i (freeze),
    .load_i   (load),
    .instr_i  (load_instr),
    .pc_i     (load_pc),
    .instr_o  (instruction),
    .pc_o     (pc_out),
    .valid_o  (valid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a latency-programmable memory model
// and a scoreboard of expected fetch addresses checked as IF/ID fills.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata, instruction, pc_out;
  logic        valid;

  logic        imem_req2;
  logic [31:0] imem_addr2, instruction2, pc_out2;
  logic        valid2;

  int          lat;
  bit          mem_en;
  int          cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held_addr = '0;
  bit          pend = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign imem_ack   = mem_en && imem_req && (cnt >= lat - 1);
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) cnt <= (!imem_req || imem_ack) ? 0 : cnt + 1;

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .valid        (valid)
  );

  // Second instance with a reset PC at the top of the address space, zero-wait memory.
  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req2),
    .imem_addr    (imem_addr2),
    .imem_ack     (imem_req2),
    .imem_rdata   (mem_word(imem_addr2)),
    .instruction  (instruction2),
    .pc_out       (pc_out2),
    .valid        (valid2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // The address must not move while a request waits for its ack.
  always @(negedge clk) begin
    if (rst && imem_req) begin
      if (pend) check("addr_stable", imem_addr, held_addr);
      held_addr <= imem_addr;
      pend      <= !imem_ack;
    end else begin
      pend <= 1'b0;
    end
  end

  // One clock; a fresh IF/ID entry appears only when freeze was low at the edge.
  task automatic step();
    logic        f_edge;
    logic [31:0] a;
    f_edge = freeze;
    @(posedge clk);
    #1;
    if (valid && !f_edge) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow: observed valid entry pc_out=%h, expected no entry", pc_out);
      end
      if (exp_q.size() != 0) begin
        a = exp_q.pop_front();
        check("sb_instr", instruction, mem_word(a));
        check("sb_pc", pc_out, a + 32'd4);
      end
    end
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    lat = 1; mem_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_instr", instruction, NOP);
    check("rst_pc", pc_out, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_req2", {31'b0, imem_req2}, 32'd0);

    // Zero-wait streaming from address 0.
    rst = 1'b1;
    #1;
    check("first_req", {31'b0, imem_req}, 32'd1);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
    for (int i = 0; i < 5; i++) begin
      check("p1_addr", imem_addr, 32'(4 * i));
      step();
      check("p1_valid", {31'b0, valid}, 32'd1);
    end

    // Three-cycle latency: valid pattern 0,0,1.
    lat = 3;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(20 + 4 * i));
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) begin
        check("p2_addr", imem_addr, 32'(20 + 4 * i));
        step();
        check("p2_valid", {31'b0, valid}, (k == 2) ? 32'd1 : 32'd0);
      end
    end

    // Four-cycle freeze with an ack arriving inside it.
    lat = 2; freeze = 1'b1;
    exp_q.push_back(32'd32);
    exp_q.push_back(32'd36);
    for (int k = 0; k < 4; k++) begin
      step();
      check("frz_instr", instruction, mem_word(32'd28));
      check("frz_pc", pc_out, 32'd32);
      check("frz_valid", {31'b0, valid}, 32'd1);
      check("frz_req", {31'b0, imem_req}, (k == 0) ? 32'd1 : 32'd0);
    end
    freeze = 1'b0;
    step();
    check("rel_req", {31'b0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'd36);
    step();
    check("rel_bubble", {31'b0, valid}, 32'd0);
    step();
    check("rel_valid", {31'b0, valid}, 32'd1);

    // Branch with ack in the same cycle; low target bits ignored.
    lat = 1; branch_taken = 1'b1; branch_addr = 32'h23;
    step();
    check("br1_valid", {31'b0, valid}, 32'd0);
    check("br1_instr", instruction, NOP);
    check("br1_pc", pc_out, 32'd0);
    check("br1_addr", imem_addr, 32'h20);
    branch_taken = 1'b0; mem_en = 1'b0;
    step();
    check("pend_valid", {31'b0, valid}, 32'd0);
    // Branch to 0x100 while the 0x20 request is outstanding.
    branch_taken = 1'b1; branch_addr = 32'h100;
    step();
    check("kill_valid", {31'b0, valid}, 32'd0);
    check("kill_addr", imem_addr, 32'h20);
    check("kill_req", {31'b0, imem_req}, 32'd1);
    branch_taken = 1'b0; mem_en = 1'b1;
    step();
    check("kill_redirect", imem_addr, 32'h100);
    check("kill_discard", {31'b0, valid}, 32'd0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    step();
    check("tgt_valid", {31'b0, valid}, 32'd1);
    step();

    // Branch and freeze together with an ack: flush wins.
    branch_taken = 1'b1; branch_addr = 32'h300; freeze = 1'b1;
    step();
    check("bf_valid", {31'b0, valid}, 32'd0);
    check("bf_instr", instruction, NOP);
    check("bf_addr", imem_addr, 32'h300);
    check("bf_req", {31'b0, imem_req}, 32'd1);
    branch_taken = 1'b0; freeze = 1'b0;
    exp_q.push_back(32'h300);
    step();
    check("bf_tgt_valid", {31'b0, valid}, 32'd1);

    // Reset while a slow request is pending, then the wrap-around instance.
    lat = 3;
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, valid}, 32'd0);
    check("mid_rst_instr", instruction, NOP);
    check("mid_rst_pc", pc_out, 32'd0);
    check("mid_rst_req", {31'b0, imem_req}, 32'd0);
    step();
    step();
    lat = 1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    rst = 1'b1;
    #1;
    check("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
    check("rerun_addr", imem_addr, 32'd0);
    step();
    check("wrap_pc0", pc_out2, 32'd0);
    check("wrap_valid", {31'b0, valid2}, 32'd1);
    check("wrap_instr", instruction2, mem_word(32'hFFFF_FFFC));
    check("wrap_addr1", imem_addr2, 32'd0);
    step();
    check("wrap_pc1", pc_out2, 32'd4);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
